// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forwarding selects, result-source values
// (shared with the decoder) and the load marker.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } result_src_e;

    localparam logic [1:0] LOAD_SRC = RES_LOAD;

    // M beats W because it holds the younger write to the same register.
    function automatic logic [1:0] fwd_sel(input logic       we_m,
                                           input logic [4:0] rd_m,
                                           input logic       we_w,
                                           input logic [4:0] rd_w,
                                           input logic [4:0] rs);
        if (we_m && rd_m != 5'd0 && rd_m == rs)      return FWD_M;
        else if (we_w && rd_w != 5'd0 && rd_w == rs) return FWD_W;
        else                                         return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_ctrl_if #(parameter int CNT_W = 32);

    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic             RegWriteE;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             clr_cnt;
    logic             StallF, StallD, FlushD, FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE, clr_cnt,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE, clr_cnt,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: load-use stall, branch flush, EX forwarding from a private M/W
// shadow of destination/write-enable, plus stall/flush event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int         CNT_W    = 32,
    parameter logic [1:0] LOAD_SRC = hazard_pkg::LOAD_SRC
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave bus
);

    logic [4:0] rd_m_q, rd_w_q;
    logic       we_m_q, we_w_q;
    logic       lw, br, stall;

    // M and W never stall, so the shadow advances on every edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_m_q <= '0;
            rd_w_q <= '0;
            we_m_q <= 1'b0;
            we_w_q <= 1'b0;
        end else begin
            rd_m_q <= bus.RdE;
            we_m_q <= bus.RegWriteE;
            rd_w_q <= rd_m_q;
            we_w_q <= we_m_q;
        end
    end

    assign lw    = (bus.ResultSrcE == LOAD_SRC) && (bus.RdE != 5'd0) &&
                   ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
    assign br    = bus.PCSrcE;
    assign stall = lw && !br;

    always_comb begin
        bus.StallF    = 1'b0;
        bus.StallD    = 1'b0;
        bus.FlushD    = 1'b1;
        bus.FlushE    = 1'b1;
        bus.ForwardAE = FWD_RF;
        bus.ForwardBE = FWD_RF;
        if (reset) begin
            bus.StallF    = stall;
            bus.StallD    = stall;
            bus.FlushD    = br;
            bus.FlushE    = lw || br;
            bus.ForwardAE = fwd_sel(we_m_q, rd_m_q, we_w_q, rd_w_q, bus.Rs1E);
            bus.ForwardBE = fwd_sel(we_m_q, rd_m_q, we_w_q, rd_w_q, bus.Rs2E);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (bus.clr_cnt),
        .en_i  (stall),
        .cnt_o (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (bus.clr_cnt),
        .en_i  (br),
        .cnt_o (bus.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a history-based reference model.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: history of (write-enable, rd) leaving EX, newest first.
    typedef struct { bit we; int rd; } wr_t;
    wr_t hist[$];
    int  sc, fc;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_fwd(input int rs);
        // Youngest matching writer that actually writes a non-zero register wins.
        for (int age = 0; age < 2 && age < hist.size(); age++)
            if (hist[age].we && hist[age].rd != 0 && hist[age].rd == rs)
                return (age == 0) ? 2 : 1;
        return 0;
    endfunction

    task automatic step();
        bit lw, br;
        #1;
        lw = (bus.ResultSrcE == 2'b01) && bus.RdE != 0 &&
             (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
        br = bus.PCSrcE;
        if (!reset) begin
            chk("StallF", int'(bus.StallF), 0);
            chk("StallD", int'(bus.StallD), 0);
            chk("FlushD", int'(bus.FlushD), 1);
            chk("FlushE", int'(bus.FlushE), 1);
            chk("FwdA",   int'(bus.ForwardAE), 0);
            chk("FwdB",   int'(bus.ForwardBE), 0);
        end else begin
            chk("StallF", int'(bus.StallF), int'(lw && !br));
            chk("StallD", int'(bus.StallD), int'(lw && !br));
            chk("FlushD", int'(bus.FlushD), int'(br));
            chk("FlushE", int'(bus.FlushE), int'(lw || br));
            chk("FwdA",   int'(bus.ForwardAE), exp_fwd(int'(bus.Rs1E)));
            chk("FwdB",   int'(bus.ForwardBE), exp_fwd(int'(bus.Rs2E)));
        end
        chk("stall_cnt", int'(bus.stall_cnt), sc);
        chk("flush_cnt", int'(bus.flush_cnt), fc);
        @(posedge clk);
        if (!reset) begin
            hist.delete();
            sc = 0;
            fc = 0;
        end else begin
            hist.push_front('{we: bit'(bus.RegWriteE), rd: int'(bus.RdE)});
            if (hist.size() > 2) void'(hist.pop_back());
            if (bus.clr_cnt) begin
                sc = 0;
                fc = 0;
            end else begin
                if (lw && !br) sc = (sc < CMAX) ? sc + 1 : CMAX;
                if (br)        fc = (fc < CMAX) ? fc + 1 : CMAX;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0; bus.RdE = 0;
        bus.RegWriteE = 0; bus.ResultSrcE = 2'b00; bus.PCSrcE = 0; bus.clr_cnt = 0;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        sc = 0;
        fc = 0;
        @(posedge clk);
        @(negedge clk);
        // Reset held with hazards on the inputs: outputs are still forced.
        bus.PCSrcE = 1; bus.ResultSrcE = 2'b01; bus.RdE = 4; bus.Rs1D = 4;
        step();
        reset = 1'b1;
        idle();
        step();

        // Forward from M then W; x0 never forwards.
        bus.RdE = 5; bus.RegWriteE = 1;
        step();
        bus.RdE = 0; bus.RegWriteE = 0; bus.Rs1E = 5;
        #1 chk("fwdA_from_M", int'(bus.ForwardAE), 2);
        step();
        #1 chk("fwdA_from_W", int'(bus.ForwardAE), 1);
        step();
        bus.Rs1E = 0;
        step();

        // Load-use stall.
        idle();
        bus.ResultSrcE = 2'b01; bus.RdE = 7; bus.Rs2D = 7;
        #1 chk("lu_StallF", int'(bus.StallF), 1);
        chk("lu_FlushD", int'(bus.FlushD), 0);
        step();
        chk("lu_stall_cnt", int'(bus.stall_cnt), 1);

        // Load-use with branch: branch wins.
        idle();
        bus.ResultSrcE = 2'b01; bus.RdE = 7; bus.Rs1D = 7; bus.PCSrcE = 1;
        #1 chk("lub_StallD", int'(bus.StallD), 0);
        chk("lub_FlushE", int'(bus.FlushE), 1);
        step();
        chk("lub_stall_cnt", int'(bus.stall_cnt), 1);
        chk("lub_flush_cnt", int'(bus.flush_cnt), 1);

        // Saturation and clear.
        idle();
        bus.clr_cnt = 1;
        step();
        bus.clr_cnt = 0; bus.PCSrcE = 1;
        for (int i = 0; i < CMAX; i++) step();
        chk("sat_full", int'(bus.flush_cnt), CMAX);
        step();
        chk("sat_hold", int'(bus.flush_cnt), CMAX);
        bus.clr_cnt = 1;
        step();
        chk("clr_wins", int'(bus.flush_cnt), 0);

        // Reset mid-operation.
        idle();
        bus.RdE = 3; bus.RegWriteE = 1;
        step();
        bus.RdE = 0; bus.RegWriteE = 0; bus.Rs1E = 3;
        bus.ResultSrcE = 2'b01; bus.RdE = 6; bus.Rs1D = 6;
        #1 chk("pre_rst_stall", int'(bus.StallF), 1);
        reset = 1'b0;
        #1 chk("rst_fwdA", int'(bus.ForwardAE), 0);
        chk("rst_stall", int'(bus.StallF), 0);
        step();
        reset = 1'b1;
        idle();
        bus.Rs1E = 3;
        #1 chk("post_rst_fwdA", int'(bus.ForwardAE), 0);
        step();

        // M over W priority.
        idle();
        bus.RdE = 9; bus.RegWriteE = 1;
        step();
        step();
        bus.RdE = 0; bus.RegWriteE = 0; bus.Rs1E = 9; bus.Rs2E = 9;
        #1 chk("prio_M_over_W", int'(bus.ForwardAE), 2);
        step();

        // Random traffic on a narrow register range to provoke matches.
        for (int i = 0; i < 600; i++) begin
            bus.Rs1D       = 5'($urandom_range(0, 3));
            bus.Rs2D       = 5'($urandom_range(0, 3));
            bus.Rs1E       = 5'($urandom_range(0, 3));
            bus.Rs2E       = 5'($urandom_range(0, 3));
            bus.RdE        = 5'($urandom_range(0, 3));
            bus.RegWriteE  = 1'($urandom_range(0, 1));
            bus.ResultSrcE = 2'($urandom_range(0, 3));
            bus.PCSrcE     = ($urandom_range(0, 3) == 0);
            bus.clr_cnt    = ($urandom_range(0, 31) == 0);
            reset          = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer and controller of the decode→execute stage register.
- Takes the execute-stage fields (Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE) and the decode-stage source registers.
- Drives the stage register's flush input, the fetch/decode stall and flush lines, and the EX operand forwarding selects.
- Keeps its own two-stage shadow of destination/write-enable (M, W), so the later stage registers do not export Rd. Also counts stall and flush events for performance monitoring.

Parameters:
- CNT_W, 32, width of each saturating event counter.
- LOAD_SRC, 2'b01, ResultSrc encoding that marks a load.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- Rs1D  in  5  decode-stage source 1.
- Rs2D  in  5  decode-stage source 2.
- Rs1E  in  5  execute-stage source 1.
- Rs2E  in  5  execute-stage source 2.
- RdE  in  5  execute-stage destination.
- RegWriteE  in  1  execute-stage register-write enable.
- ResultSrcE  in  2  execute-stage result select.
- PCSrcE  in  1  taken branch/jump resolved in EX.
- clr_cnt  in  1  synchronous clear of both counters.
- StallF  out  1  hold PC.
- StallD  out  1  hold fetch→decode register.
- FlushD  out  1  zero fetch→decode register.
- FlushE  out  1  zero decode→execute register.
- ForwardAE  out  2  operand A select: 00 regfile, 01 W result, 10 M ALU result.
- ForwardBE  out  2  operand B select, same encoding.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  control-hazard flush cycles.

Behaviour:
- Shadow pipeline, clocked every edge (never stalled, because the M/W stages never stall):
  - RdM ← RdE, RegWriteM ← RegWriteE.
  - RdW ← RdM, RegWriteW ← RegWriteM.
- Forwarding, combinational from the shadow state:
  - ForwardAE = 10 if RegWriteM & RdM≠0 & RdM==Rs1E.
  - Otherwise 01 if RegWriteW & RdW≠0 & RdW==Rs1E.
  - Otherwise 00.
  - M has priority over W. ForwardBE is identical using Rs2E.
- Load-use: lw = (ResultSrcE==LOAD_SRC) & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- Control hazard: br = PCSrcE.
- Output equations:
  - StallF = StallD = lw & ~br.
  - FlushD = br.
  - FlushE = lw | br.
- Simultaneous lw and br: branch wins. No stall, both D and E are flushed, because the D instruction is discarded anyway.
- Latency: all hazard outputs are combinational in the same cycle. Forwarding reflects instructions that left EX 1 cycle (M) or 2 cycles (W) earlier.
- Counters:
  - stall_cnt increments on each cycle with lw & ~br.
  - flush_cnt increments on each cycle with br.
  - Both saturate at all-ones and never wrap.
  - clr_cnt has priority over increment; that cycle's event is not counted.
- Reset (reset==0 at a rising edge):
  - RdM, RdW, RegWriteM, RegWriteW, stall_cnt, flush_cnt all become 0.
  - While reset is low: FlushD=FlushE=1, StallF=StallD=0, ForwardAE=ForwardBE=00, regardless of other inputs.
  - Reset asserted mid-stall drops the stall that cycle. The first cycle after release evaluates normally from the cleared shadow state.
- x0 never forwards and never stalls.

Decomposition:
- Shared package `hazard_pkg` holds:
  - forward encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - LOAD_SRC;
  - the ResultSrc enumerations shared with the decoder.
- Natural sub-module: `sat_counter` (parameterised by CNT_W, with clear and enable), instantiated twice.

Test Plan:
- Forward from M: RdE=5, RegWriteE=1 for one cycle, then Rs1E=5 → ForwardAE=10 next cycle and 01 the cycle after; Rs1E=0 with RdM=0 → 00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7, PCSrcE=0 → StallF=StallD=FlushE=1, FlushD=0, stall_cnt increments by 1.
- Load-use plus branch: ResultSrcE=01, RdE=7, Rs1D=7, PCSrcE=1 → StallF=StallD=0, FlushD=FlushE=1; flush_cnt +1, stall_cnt unchanged.
- Saturation and clear: force flush_cnt to all-ones with 2^CNT_W−1 branches (bench uses CNT_W=4) → stays 4'hF on the next branch. clr_cnt=1 together with a branch → 0.
- Reset mid-operation: with RdM=3 forwarding active, drive reset=0 for one edge → ForwardAE=00, FlushD=FlushE=1 while low, counters 0. After release, Rs1E=3 → 00.
- Priority of M over W: back-to-back writes to x9 then Rs1E=9 → ForwardAE=10, not 01.
